// File: rtl/audio_fifo_if.sv
// Sample-stream bundle between the synth stage (writer), the I2S transmitter
// (reader) and the audio FIFO. Data is two's-complement audio carried as raw bits.
interface audio_fifo_if #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 16
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic             wr_en;
  logic [WIDTH-1:0] wr_data;
  logic             full;
  logic             rd_en;
  logic [WIDTH-1:0] rd_data;
  logic             rd_valid;
  logic             empty;
  logic [CW-1:0]    count;
  logic             overflow;
  logic             underrun;
  logic             clr_flags;

  modport master (
    output wr_en, wr_data, rd_en, clr_flags,
    input  full, rd_data, rd_valid, empty, count, overflow, underrun
  );

  modport slave (
    input  wr_en, wr_data, rd_en, clr_flags,
    output full, rd_data, rd_valid, empty, count, overflow, underrun
  );
endinterface

// File: rtl/audio_fifo.sv
// Circular-buffer audio sample FIFO with registered read, sticky overflow/underrun.
// Optional: define AUDIO_FIFO_UNDERRUN_HOLD_EN to hold the last sample on underrun.
module audio_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 16
) (
  input  logic         clk,
  input  logic         reset,
  audio_fifo_if.slave  bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];

  logic [AW-1:0]    wr_ptr_reg;
  logic [AW-1:0]    rd_ptr_reg;
  logic [CW-1:0]    count_reg;
  logic [CW-1:0]    count_next;
  logic             full_reg;
  logic             empty_reg;
  logic [WIDTH-1:0] rd_data_reg;
  logic             rd_valid_reg;

  logic             rd_acc;
  logic             wr_acc;
  logic             underrun_evt;
  logic             overflow_evt;

  // flag index 0 = overflow, 1 = underrun
  logic [1:0]       flag_reg;
  logic [1:0]       flag_evt;

  // A full FIFO still takes a write when a read frees a slot on the same edge.
  assign rd_acc       = bus.rd_en && !empty_reg;
  assign wr_acc       = bus.wr_en && (!full_reg || rd_acc);
  assign overflow_evt = bus.wr_en && !wr_acc;
  assign underrun_evt = bus.rd_en && empty_reg;
  assign flag_evt     = {underrun_evt, overflow_evt};

  always_comb begin
    count_next = count_reg;
    if (wr_acc && !rd_acc) begin
      count_next = count_reg + CW'(1);
    end else if (rd_acc && !wr_acc) begin
      count_next = count_reg - CW'(1);
    end
  end

  // Storage is left unreset so it maps onto block RAM.
  always_ff @(posedge clk) begin
    if (wr_acc) begin
      mem[wr_ptr_reg] <= bus.wr_data;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
      full_reg   <= 1'b0;
      empty_reg  <= 1'b1;
    end else begin
      if (wr_acc) begin
        wr_ptr_reg <= wr_ptr_reg + AW'(1);
      end
      if (rd_acc) begin
        rd_ptr_reg <= rd_ptr_reg + AW'(1);
      end
      count_reg <= count_next;
      full_reg  <= (count_next == CW'(DEPTH));
      empty_reg <= (count_next == '0);
    end
  end

  // Read port: the memory read happens before any same-edge write to that slot.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_data_reg  <= '0;
      rd_valid_reg <= 1'b0;
    end else begin
      rd_valid_reg <= rd_acc;
      if (rd_acc) begin
        rd_data_reg <= mem[rd_ptr_reg];
      end
`ifdef AUDIO_FIFO_UNDERRUN_HOLD_EN
`else
      else if (underrun_evt) begin
        rd_data_reg <= '0;
      end
`endif
    end
  end

  // Sticky flags: a new event on the same edge as a clear keeps the flag set.
  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_flag
      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          flag_reg[gi] <= 1'b0;
        end else if (flag_evt[gi]) begin
          flag_reg[gi] <= 1'b1;
        end else if (bus.clr_flags) begin
          flag_reg[gi] <= 1'b0;
        end
      end
    end
  endgenerate

  assign bus.full     = full_reg;
  assign bus.empty    = empty_reg;
  assign bus.count    = count_reg;
  assign bus.rd_data  = rd_data_reg;
  assign bus.rd_valid = rd_valid_reg;
  assign bus.overflow = flag_reg[0];
  assign bus.underrun = flag_reg[1];
endmodule

// File: tb/tb_audio_fifo.sv
// Directed scoreboard bench for audio_fifo (DEPTH=16, WIDTH=16): stimulus pushes
// expected pops, a negedge monitor compares every RD_VALID sample.
module tb_audio_fifo;
  localparam int DEPTH = 16;
  localparam int WIDTH = 16;

  logic clk;
  logic reset;
  int   assertions;
  int   failures;
  logic [WIDTH-1:0] exp_q[$];

  audio_fifo_if #(.DEPTH(DEPTH), .WIDTH(WIDTH)) bus ();

  audio_fifo #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    assertions++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got 0x%0h, required 0x%0h (t=%0t)", name, act, req, $time);
    end else begin
      $display("ok   %s: 0x%0h", name, act);
    end
  endtask

  // Monitor: every RD_VALID must match the oldest expected sample.
  always @(negedge clk) begin
    if (bus.rd_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("rd_valid_unexpected", 32'(bus.rd_valid), 32'(exp_q.size() != 0));
      end else begin
        check("rd_data_pop", 32'(bus.rd_data), 32'(exp_q.pop_front()));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write(input logic [WIDTH-1:0] d);
    bus.wr_en   = 1'b1;
    bus.wr_data = d;
    tick();
    bus.wr_en   = 1'b0;
  endtask

  task automatic read_exp(input logic [WIDTH-1:0] e);
    bus.rd_en = 1'b1;
    exp_q.push_back(e);
    tick();
    bus.rd_en = 1'b0;
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_count"},    32'(bus.count),    32'd0);
    check({tag, "_empty"},    32'(bus.empty),    32'd1);
    check({tag, "_full"},     32'(bus.full),     32'd0);
    check({tag, "_rd_data"},  32'(bus.rd_data),  32'd0);
    check({tag, "_rd_valid"}, 32'(bus.rd_valid), 32'd0);
    check({tag, "_overflow"}, 32'(bus.overflow), 32'd0);
    check({tag, "_underrun"}, 32'(bus.underrun), 32'd0);
  endtask

  logic [WIDTH-1:0] under_exp;

  initial begin
    assertions    = 0;
    failures      = 0;
    reset         = 1'b0;
    bus.wr_en     = 1'b0;
    bus.wr_data   = '0;
    bus.rd_en     = 1'b0;
    bus.clr_flags = 1'b0;
    repeat (3) tick();
    check_reset_state("reset");
    reset = 1'b1;
    tick();

    // Basic ordering, 1-cycle read latency
    for (int i = 1; i <= 4; i++) write(16'(i));
    check("t1_count4", 32'(bus.count), 32'd4);
    for (int i = 1; i <= 4; i++) read_exp(16'(i));
    check("t1_empty", 32'(bus.empty), 32'd1);
    tick();

    // Fill to full, drop 17th
    for (int i = 1; i <= 16; i++) write(16'(i));
    check("t2_full", 32'(bus.full), 32'd1);
    check("t2_count16", 32'(bus.count), 32'd16);
    check("t2_ovf_before", 32'(bus.overflow), 32'd0);
    write(16'h0011);
    check("t2_overflow", 32'(bus.overflow), 32'd1);
    check("t2_count_after_drop", 32'(bus.count), 32'd16);
    bus.clr_flags = 1'b1;
    tick();
    bus.clr_flags = 1'b0;
    check("t2_ovf_cleared", 32'(bus.overflow), 32'd0);

    // Full with simultaneous write and read
    bus.wr_en   = 1'b1;
    bus.wr_data = 16'hBEEF;
    bus.rd_en   = 1'b1;
    exp_q.push_back(16'h0001);
    tick();
    bus.wr_en = 1'b0;
    bus.rd_en = 1'b0;
    check("t3_count16", 32'(bus.count), 32'd16);
    check("t3_full", 32'(bus.full), 32'd1);
    check("t3_overflow0", 32'(bus.overflow), 32'd0);
    for (int i = 2; i <= 16; i++) read_exp(16'(i));
    read_exp(16'hBEEF);
    check("t3_empty", 32'(bus.empty), 32'd1);
    tick();

    // Underrun behaviour
    write(16'h1234);
    read_exp(16'h1234);
    bus.rd_en = 1'b1;
    tick();
    bus.rd_en = 1'b0;
`ifdef AUDIO_FIFO_UNDERRUN_HOLD_EN
    under_exp = 16'h1234;
`else
    under_exp = 16'h0000;
`endif
    check("t4_underrun", 32'(bus.underrun), 32'd1);
    check("t4_rd_valid0", 32'(bus.rd_valid), 32'd0);
    check("t4_rd_data", 32'(bus.rd_data), 32'(under_exp));
    tick();
    tick();
    check("t4_rd_data_hold", 32'(bus.rd_data), 32'(under_exp));
    bus.clr_flags = 1'b1;
    bus.rd_en     = 1'b1;
    tick();
    bus.rd_en = 1'b0;
    check("t4_event_beats_clear", 32'(bus.underrun), 32'd1);
    tick();
    bus.clr_flags = 1'b0;
    check("t4_underrun_cleared", 32'(bus.underrun), 32'd0);

    // Interleaved traffic wrapping both pointers
    for (int i = 0; i < 20; i++) begin
      write(16'h2000 + 16'(i));
      read_exp(16'h2000 + 16'(i));
    end
    check("t5_empty_after_wrap", 32'(bus.empty), 32'd1);
    bus.rd_en = 1'b1;
    tick();
    bus.rd_en = 1'b0;
    write(16'h3000);
    write(16'h3001);
    write(16'h3002);
    check("t5_count3", 32'(bus.count), 32'd3);
    check("t5_underrun_set", 32'(bus.underrun), 32'd1);

    // Asynchronous reset mid-cycle, away from any clock edge
    @(posedge clk);
    #2;
    reset = 1'b0;
    #1;
    check_reset_state("async_reset");
    @(posedge clk);
    #1;
    reset = 1'b1;
    bus.clr_flags = 1'b1;
    tick();
    bus.clr_flags = 1'b0;
    check("post_reset_overflow", 32'(bus.overflow), 32'd0);
    check("post_reset_underrun", 32'(bus.underrun), 32'd0);
    check("post_reset_empty", 32'(bus.empty), 32'd1);
    write(16'hA5A5);
    write(16'h5A5A);
    read_exp(16'hA5A5);
    read_exp(16'h5A5A);

    for (int i = 0; i < 10 && exp_q.size() != 0; i++) tick();
    tick();
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    check("final_empty", 32'(bus.empty), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
    $finish;
  end
endmodule

// File: doc/audio_fifo.md
AUDIO_FIFO -- requirements
Module: audio_fifo

Interface
REQ-001 The clocking and reset arrangement SHALL be: one clock; reset is asynchronous and active-low.
REQ-002 Parameter DEPTH, default 16, SHALL set sample storage entries; power of two, 4..256.
REQ-003 Parameter WIDTH, default 16, SHALL set the signed audio sample width.
REQ-004 CLK  in  1  SHALL be the single system clock; all logic on its rising edge.
REQ-005 RESET  in  1  SHALL be the asynchronous active-low reset.
REQ-006 WR_EN  in  1  SHALL be the write strobe from the synth stage, one sample per high cycle.
REQ-007 WR_DATA  in  WIDTH  SHALL be the mono sample written when WR_EN is high.
REQ-008 FULL  out  1  SHALL be high when COUNT equals DEPTH; it feeds the synth FIFO_FULL input.
REQ-009 RD_EN  in  1  SHALL be the read strobe from the I2S transmitter.
REQ-010 RD_DATA  out  WIDTH  SHALL be the registered read sample.
REQ-011 RD_VALID  out  1  SHALL be high for one cycle when RD_DATA holds a newly popped sample.
REQ-012 EMPTY  out  1  SHALL be high when COUNT equals 0.
REQ-013 COUNT  out  log2(DEPTH)+1  SHALL be the current occupancy.
REQ-014 OVERFLOW  out  1  SHALL be a sticky flag for a dropped write.
REQ-015 UNDERRUN  out  1  SHALL be a sticky flag for a read while empty.
REQ-016 CLR_FLAGS  in  1  SHALL clear OVERFLOW and UNDERRUN.

Function
REQ-017 Storage SHALL be a circular buffer with write and read pointers of log2(DEPTH) bits wrapping from DEPTH-1 to 0.
REQ-018 Write accepted = WR_EN and (not FULL or read accepted in the same cycle); accepted data SHALL be stored at the write pointer, which then increments.
REQ-019 Read accepted = RD_EN and not EMPTY; RD_DATA SHALL take the entry at the read pointer on the next edge, RD_VALID high that cycle (1-cycle latency), read pointer increments.
REQ-020 There SHALL be no fall-through: a write into an empty FIFO is not readable in the same cycle.
REQ-021 COUNT: +1 on write only, -1 on read only, unchanged on both or neither.
REQ-022 FULL, EMPTY and COUNT SHALL be registered and reflect the state after the current edge.
REQ-023 Full with WR_EN and RD_EN: both accepted, COUNT stays DEPTH, OVERFLOW unchanged.
REQ-024 Full with WR_EN only: write dropped, storage unchanged, OVERFLOW set next cycle.
REQ-025 Empty with RD_EN (regardless of WR_EN): RD_VALID stays low, UNDERRUN set next cycle, RD_DATA per REQ-030/031.
REQ-026 CLR_FLAGS SHALL clear both flags next cycle; a new flag event in the same cycle wins (flag set).
REQ-027 RD_DATA SHALL hold its value in all cycles without a read attempt.

Reset
REQ-028 On RESET low, immediately and independent of CLK: pointers 0, COUNT 0, EMPTY 1, FULL 0, RD_DATA 0, RD_VALID 0, OVERFLOW 0, UNDERRUN 0; storage contents need not be cleared.
REQ-029 Reset asserted mid-stream SHALL discard all buffered samples; first accepted write after release SHALL be the first sample read.

Configuration
REQ-030 Macro AUDIO_FIFO_UNDERRUN_HOLD_EN defined: on an underrun read, RD_DATA SHALL retain the last popped sample (click-free hold).
REQ-031 Macro undefined: on an underrun read, RD_DATA SHALL be driven to 0 on the next edge (silence).

Verification
REQ-032 After reset, write 0x0001..0x0004 on 4 cycles, then RD_EN 4 cycles -> RD_DATA 0x0001..0x0004 each one cycle after its RD_EN, RD_VALID high 4 cycles, EMPTY 1 at end.
REQ-033 Write 17 samples with DEPTH=16, no reads -> FULL 1 after 16th, 17th dropped, OVERFLOW 1, COUNT 16; reading returns samples 1..16.
REQ-034 Full, simultaneous WR_EN (0xBEEF) and RD_EN -> COUNT stays 16, OVERFLOW 0, 0xBEEF read as 16th subsequent sample.
REQ-035 Pop 0x1234, then RD_EN while empty -> UNDERRUN 1, RD_VALID 0, RD_DATA 0x1234 with macro, 0x0000 without.
REQ-036 Write 20 and read 20 interleaved to wrap pointers, assert RESET mid-stream, then CLR_FLAGS -> all REQ-028 values, flags 0, data order preserved before reset.
